muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock) and `reset` (in, 1), where `reset` is synchronous and active-high.
REQ-002 SHALL have port `StartE` (in, 1): a valid RV32M operation is in Execute.
REQ-003 SHALL have port `Funct3E` (in, 3): operation select.
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-004 SHALL have ports `SrcAE` and `SrcBE` (in, 32 each): rs1 and rs2 operands, already forwarded.
REQ-005 SHALL have port `FlushE` (in, 1): Execute flush from the hazard unit.
REQ-006 SHALL have port `StallMD` (out, 1): stall request to the hazard unit, which holds F, D and E.
REQ-007 SHALL have port `DoneMD` (out, 1): one-cycle pulse marking the cycle in which `ResultMD` is valid.
REQ-008 SHALL have port `ResultMD` (out, 32): the operation result.

Function
REQ-009 SHALL implement states IDLE, CALC and DONE.
REQ-010 In IDLE with StartE=1 and FlushE=0 (cycle N), SHALL:
- capture operands, Funct3E and operand signs;
- transition to CALC;
- load the iteration counter with 31.
REQ-011 SHALL drive StallMD = (IDLE & StartE & ~FlushE) | CALC, combinationally.
REQ-012 In CALC, SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-013 SHALL leave CALC for DONE when the counter is 0 after that step, so DONE occurs at cycle N+33.
REQ-014 In DONE, SHALL assert DoneMD=1, drive StallMD=0 and return to IDLE the next cycle.
REQ-015 SHALL hold ResultMD stable from DONE until the next accepted start.
REQ-016 SHALL select the multiply result by Funct3E:
- MUL: low 32 bits of the 64-bit product;
- MULH: high 32 bits, signed x signed;
- MULHSU: high 32 bits, signed x unsigned;
- MULHU: high 32 bits, unsigned x unsigned.
REQ-017 For divides, SHALL set the quotient sign to the XOR of the operand signs and the remainder sign to the dividend sign; unsigned variants ignore signs.
REQ-018 On divide by zero (SrcBE=0), SHALL go IDLE->DONE directly at N+1, with quotient 0xFFFFFFFF and remainder = SrcAE.
REQ-019 On signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF), SHALL go IDLE->DONE at N+1, with quotient 0x80000000 and remainder 0.
REQ-020 SHALL ignore StartE in CALC and DONE.
REQ-021 FlushE=1 in any state SHALL force IDLE on the next edge with DoneMD=0; FlushE overrides StartE in the same cycle.
REQ-022 SHALL keep all sign fix-ups and the 64-bit accumulator free of width truncation until final result selection.

Reset
REQ-023 With reset=1 at a clk edge, SHALL set state=IDLE, counter=0, DoneMD=0, ResultMD=0 and clear all operand registers.
REQ-024 SHALL hold StallMD=0 while reset is asserted.
REQ-025 Reset mid-CALC SHALL abandon the operation with no DoneMD pulse.
REQ-026 reset SHALL take priority over FlushE and StartE.

Configuration
REQ-027 With macro MULDIV_FAST_MUL_EN defined, SHALL compute multiplies with a single-cycle 33x33 signed multiplier: IDLE->DONE at N+1, StallMD high for cycle N only.
REQ-028 Without MULDIV_FAST_MUL_EN, multiplies SHALL use the 32-step iterative path of REQ-012.
REQ-029 Divide behaviour SHALL be identical with and without MULDIV_FAST_MUL_EN.

Structure
REQ-030 SHALL take the following from shared package muldiv_pkg:
- XLEN=32;
- state enum (IDLE/CALC/DONE);
- the eight Funct3 operation constants;
- constant DIV_ITER=32.
REQ-031 SHALL instantiate one sub-module, muldiv_step: combinational single-iteration add/subtract-and-shift datapath; the FSM, counter and registers stay in muldiv_sequencer.

Verification
REQ-032 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> ResultMD=0xFFFFFFFE with DoneMD at N+33 (N+1 with MULDIV_FAST_MUL_EN); StallMD high N..N+32.
REQ-033 DIV, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DoneMD at N+33.
REQ-034 DIVU, 5 / 0 -> 0xFFFFFFFF at N+1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1.
REQ-035 Start DIVU 100 / 7, assert FlushE at N+10 -> IDLE at N+11, no DoneMD, StallMD=0; a following start at N+12 yields a correct 14 at N+45.
REQ-036 StartE held high through CALC with changing operands -> single operation, result from cycle-N operands only; reset at N+5 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared widths, FSM state encoding and RV32M funct3 codes for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add (multiply) or restoring shift-subtract (divide) on a 64-bit accumulator.
// Multiply keeps {hi, multiplier}; divide keeps {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opb_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   shl;
    logic [XLEN+1:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
        // Partial remainder is 33 bits after the shift, so the compare must not drop acc_i[63].
        shl      = {acc_i, 1'b0};
        div_diff = {1'b0, shl[2*XLEN:XLEN]} - {2'b00, opb_i};
        if (is_div_i) begin
            if (!div_diff[XLEN+1])
                acc_o = {div_diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
            else
                acc_o = shl[2*XLEN-1:0];
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32-cycle iterative datapath, early exit for divide-by-zero and signed overflow.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one cycle with a 33x33 signed multiplier.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMD,
    output logic            DoneMD,
    output logic [XLEN-1:0] ResultMD
);

    localparam logic [4:0] CNT_INIT = 5'(DIV_ITER - 1);

    state_t              state_q;
    logic [4:0]          cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opb_q;
    logic [2:0]          funct_q;
    logic                a_neg_q;
    logic                b_neg_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                start_acc;
    logic                a_signed, b_signed;
    logic                a_neg_d, b_neg_d;
    logic [XLEN-1:0]     a_mag_d, b_mag_d;
    logic                div_zero, div_ovf, early_d;
    logic [XLEN-1:0]     early_res_d;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem;
    logic [XLEN-1:0]     result_d;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;
    logic [1:0]               fast_unused;
`endif

    assign start_acc = (state_q == IDLE) && StartE && !FlushE;
    assign StallMD   = !reset && (start_acc || (state_q == CALC));
    assign DoneMD    = done_q;
    assign ResultMD  = result_q;

    muldiv_step u_step (
        .is_div_i (funct_q[2]),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        a_signed = (Funct3E == F3_MULH) || (Funct3E == F3_MULHSU) ||
                   (Funct3E == F3_DIV)  || (Funct3E == F3_REM);
        b_signed = (Funct3E == F3_MULH) || (Funct3E == F3_DIV) || (Funct3E == F3_REM);
        a_neg_d  = a_signed && SrcAE[XLEN-1];
        b_neg_d  = b_signed && SrcBE[XLEN-1];
        a_mag_d  = a_neg_d ? -SrcAE : SrcAE;
        b_mag_d  = b_neg_d ? -SrcBE : SrcBE;

        div_zero = f3_is_div(Funct3E) && (SrcBE == '0);
        div_ovf  = ((Funct3E == F3_DIV) || (Funct3E == F3_REM)) &&
                   (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
        early_d  = div_zero || div_ovf;

        // Funct3E[1] distinguishes REM/REMU from DIV/DIVU.
        early_res_d = '0;
        if (div_zero)
            early_res_d = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
        else if (div_ovf)
            early_res_d = Funct3E[1] ? 32'h0000_0000 : 32'h8000_0000;

`ifdef MULDIV_FAST_MUL_EN
        fast_a      = {a_signed && SrcAE[XLEN-1], SrcAE};
        fast_b      = {b_signed && SrcBE[XLEN-1], SrcBE};
        fast_p      = fast_a * fast_b;
        fast_unused = fast_p[2*XLEN+1:2*XLEN];
        if (!f3_is_div(Funct3E)) begin
            early_d     = 1'b1;
            early_res_d = (Funct3E == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
        end
`endif

        // Sign fix-up on full widths; truncation only happens at the final select.
        prod = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
        quot = (a_neg_q ^ b_neg_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = a_neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

        if (funct_q[2])
            result_d = funct_q[1] ? rem : quot;
        else
            result_d = (funct_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            funct_q  <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (FlushE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (StartE) begin
                            funct_q <= Funct3E;
                            a_neg_q <= a_neg_d;
                            b_neg_q <= b_neg_d;
                            opb_q   <= b_mag_d;
                            acc_q   <= {{XLEN{1'b0}}, a_mag_d};
                            cnt_q   <= CNT_INIT;
                            if (early_d) begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                result_q <= early_res_d;
                            end else begin
                                state_q  <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= result_d;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected result and completion cycle,
// a negedge monitor pops and compares on every DoneMD.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StartE = 1'b0;
    logic [2:0]  Funct3E = 3'b000;
    logic [31:0] SrcAE = 32'h0;
    logic [31:0] SrcBE = 32'h0;
    logic        FlushE = 1'b0;
    logic        StallMD;
    logic        DoneMD;
    logic [31:0] ResultMD;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .Funct3E  (Funct3E),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .FlushE   (FlushE),
        .StallMD  (StallMD),
        .DoneMD   (DoneMD),
        .ResultMD (ResultMD)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && DoneMD === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: DoneMD=1 at cycle %0d, expected no completion", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, ResultMD, e.res);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    // Drives one operation at the current negedge (cycle N), counts StallMD-high cycles over N..N+lat
    // and returns at N+lat+1. With hold set, StartE stays high and operands keep changing.
    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input bit hold);
        int st;
        st      = 0;
        Funct3E = f;
        SrcAE   = a;
        SrcBE   = b;
        StartE  = 1'b1;
        sb.push_back('{name, exp, cyc + lat});
        for (int k = 0; k <= lat; k++) begin
            #1;
            if (StallMD === 1'b1) st++;
            @(negedge clk);
            if (hold) begin
                SrcAE   = SrcAE + 32'd13;
                SrcBE   = SrcBE + 32'd1;
                Funct3E = Funct3E ^ 3'b010;
            end
            if (k == lat || (k == 0 && !hold)) StartE = 1'b0;
        end
        check({name, "_stall_cycles"}, 32'(st), 32'(lat));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        StartE = 1'b1;
        #1;
        check("reset_stall", {31'b0, StallMD}, 32'h0);
        check("reset_done", {31'b0, DoneMD}, 32'h0);
        check("reset_result", ResultMD, 32'h0);
        StartE = 1'b0;
        reset  = 1'b0;
        @(negedge clk);

        issue("mulhu_ff_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        issue("mul_ff_ff",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 1'b0);
        issue("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b0);
        issue("mulhsu_m1_ff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        issue("mul_7_6",       3'b000, 32'd7,         32'd6,         32'h0000_002A, MUL_LAT, 1'b0);
        issue("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0);
        issue("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, 1'b0);
        issue("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, 1'b0);
        issue("div_7_m2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
        issue("rem_7_m2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT, 1'b0);
        issue("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT, 1'b0);
        issue("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT, 1'b0);
        issue("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       1'b0);
        issue("remu_5_0",      3'b111, 32'd5,         32'd0,         32'd5,         1,       1'b0);
        issue("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       1'b0);
        issue("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,       1'b0);
        issue("div_m7_0",      3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,       1'b0);
        issue("rem_m7_0",      3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,       1'b0);
        repeat (3) @(negedge clk);
        check("result_hold", ResultMD, 32'hFFFF_FFF9);

        // Flush mid-divide: no completion, then a clean restart two cycles after the flush.
        Funct3E = 3'b101;
        SrcAE   = 32'd100;
        SrcBE   = 32'd7;
        StartE  = 1'b1;
        n       = cyc;
        @(negedge clk);
        StartE = 1'b0;
        repeat (9) @(negedge clk);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        check("flush_stall", {31'b0, StallMD}, 32'h0);
        check("flush_cycle", 32'(cyc), 32'(n + 11));
        @(negedge clk);
        issue("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0);

        issue("divu_held_start", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);

        // Reset mid-CALC: operation abandoned, outputs cleared.
        Funct3E = 3'b101;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd3;
        StartE  = 1'b1;
        repeat (5) @(negedge clk);
        reset  = 1'b1;
        StartE = 1'b0;
        #1;
        check("rst_mid_stall", {31'b0, StallMD}, 32'h0);
        @(negedge clk);
        check("rst_after_done", {31'b0, DoneMD}, 32'h0);
        check("rst_after_result", ResultMD, 32'h0);
        check("rst_after_stall", {31'b0, StallMD}, 32'h0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue("remu_after_rst", 3'b111, 32'd1000, 32'd3, 32'd1, DIV_LAT, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
